// File: rtl/result_flag_sel_pipe.sv
// Result/flag selector feeding a 2-entry valid/ready stage (output + skid register),
// with an architectural status register updated as each word leaves the stage.
module result_flag_sel_pipe #(
    parameter int WIDTH = 8,
    parameter int FLAGW = 4,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NSRC*WIDTH-1:0]  in_data,
    input  logic [NSRC*FLAGW-1:0]  in_flags,
    input  logic [SELW-1:0]        sel,
    input  logic                   flag_upd,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [FLAGW-1:0]       out_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLAGW-1:0]       status,
    output logic                   sel_err,
    input  logic                   status_clr
);

    logic [WIDTH-1:0] sel_data;
    logic [FLAGW-1:0] sel_flags;
    logic             sel_ok;
    logic             word_upd;

    // Skid entry (_p0) and output entry (_p1)
    logic [WIDTH-1:0] data_p0, data_p1;
    logic [FLAGW-1:0] flags_p0, flags_p1;
    logic             upd_p0, upd_p1;
    logic             vld_p0, vld_p1;

    logic accept_in;
    logic accept_out;

    // Out-of-range selects match no source and yield an all-zero, non-updating word
    always_comb begin
        sel_data  = '0;
        sel_flags = '0;
        sel_ok    = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                sel_data  = in_data[k*WIDTH +: WIDTH];
                sel_flags = in_flags[k*FLAGW +: FLAGW];
                sel_ok    = 1'b1;
            end
        end
        word_upd = flag_upd & sel_ok;
    end

    assign accept_in  = in_valid & ~vld_p0;
    assign accept_out = vld_p1 & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p0  <= '0;
            flags_p0 <= '0;
            upd_p0   <= 1'b0;
            vld_p0   <= 1'b0;
            data_p1  <= '0;
            flags_p1 <= '0;
            upd_p1   <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (!vld_p1 || accept_out) begin
            if (vld_p0) begin
                data_p1  <= data_p0;
                flags_p1 <= flags_p0;
                upd_p1   <= upd_p0;
                vld_p1   <= 1'b1;
                vld_p0   <= 1'b0;
            end else if (accept_in) begin
                data_p1  <= sel_data;
                flags_p1 <= sel_flags;
                upd_p1   <= word_upd;
                vld_p1   <= 1'b1;
            end else begin
                vld_p1   <= 1'b0;
            end
        end else if (accept_in) begin
            data_p0  <= sel_data;
            flags_p0 <= sel_flags;
            upd_p0   <= word_upd;
            vld_p0   <= 1'b1;
        end
    end

    // Clear outranks both the flag update and the out-of-range set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status  <= '0;
            sel_err <= 1'b0;
        end else if (status_clr) begin
            status  <= '0;
            sel_err <= 1'b0;
        end else begin
            if (accept_out && upd_p1)
                status <= flags_p1;
            if (accept_in && !sel_ok)
                sel_err <= 1'b1;
        end
    end

    assign in_ready  = ~vld_p0;
    assign out_data  = data_p1;
    assign out_flags = flags_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_result_flag_sel_pipe.sv
// Directed bench for result_flag_sel_pipe: a 4-source instance for the main flow and a
// 3-source instance sharing the same stimulus to exercise out-of-range selects.
module tb_result_flag_sel_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [15:0] in_flags;
    logic [1:0]  sel;
    logic        flag_upd;
    logic        in_valid;
    logic        out_ready;
    logic        status_clr;

    logic        in_ready,  out_valid,  sel_err;
    logic [7:0]  out_data;
    logic [3:0]  out_flags, status;

    logic        in_ready3, out_valid3, sel_err3;
    logic [7:0]  out_data3;
    logic [3:0]  out_flags3, status3;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    result_flag_sel_pipe #(.WIDTH(8), .FLAGW(4), .NSRC(4), .SELW(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_flags(in_flags), .sel(sel),
        .flag_upd(flag_upd), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_flags(out_flags), .out_valid(out_valid), .out_ready(out_ready), .status(status),
        .sel_err(sel_err), .status_clr(status_clr)
    );

    result_flag_sel_pipe #(.WIDTH(8), .FLAGW(4), .NSRC(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_flags(in_flags[11:0]), .sel(sel),
        .flag_upd(flag_upd), .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_flags(out_flags3), .out_valid(out_valid3), .out_ready(out_ready), .status(status3),
        .sel_err(sel_err3), .status_clr(status_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put one word on source slot s with the given data/flags/upd, valid asserted
    task automatic drive(input int s, input logic [7:0] d, input logic [3:0] f, input logic u);
        sel                  = 2'(s);
        in_data[s*8 +: 8]    = d;
        in_flags[s*4 +: 4]   = f;
        flag_upd             = u;
        in_valid             = 1'b1;
    endtask

    initial begin
        int sent;
        int rcvd;
        int cycles;
        logic fire_in, fire_out;

        rst_n = 1'b0; in_data = '0; in_flags = '0; sel = '0; flag_upd = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; status_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_status",    32'(status),    0);
        chk("rst_sel_err",   32'(sel_err),   0);

        // 1: single word through an empty stage
        drive(2, 8'hA5, 4'b1000, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_data",  32'(out_data),  32'hA5);
        chk("t1_out_flags", 32'(out_flags), 32'h8);
        chk("t1_status_pre", 32'(status),   0);
        tick();
        chk("t1_status",    32'(status),    32'h8);
        chk("t1_drained",   32'(out_valid), 0);

        // 2: back-pressure fills output then skid
        out_ready = 1'b0;
        drive(0, 8'h11, 4'b0001, 1'b0);
        tick();
        chk("t2_ready_after_first", 32'(in_ready), 1);
        drive(0, 8'h22, 4'b0001, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t2_ready_full", 32'(in_ready), 0);
        chk("t2_hold_11",    32'(out_data), 32'h11);
        tick();
        chk("t2_stable_11",  32'(out_data), 32'h11);
        chk("t2_stable_vld", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("t2_next_22",    32'(out_data), 32'h22);
        chk("t2_ready_back", 32'(in_ready), 1);
        tick();
        chk("t2_empty",      32'(out_valid), 0);
        chk("t2_status_kept", 32'(status), 32'h8);

        // 3: out-of-range select on the 3-source instance
        drive(3, 8'hEE, 4'b1111, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t3_valid",   32'(out_valid3), 1);
        chk("t3_data0",   32'(out_data3),  0);
        chk("t3_flags0",  32'(out_flags3), 0);
        chk("t3_sel_err", 32'(sel_err3),   1);
        chk("t3_no_err4", 32'(sel_err),    0);
        tick();
        chk("t3_status_kept", 32'(status3), 32'h8);
        chk("t3_err_sticky",  32'(sel_err3), 1);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("t3_clr_err",    32'(sel_err3), 0);
        chk("t3_clr_status", 32'(status3),  0);
        chk("t3_clr_status4", 32'(status),  0);

        // 4: a non-updating word leaves status alone
        drive(1, 8'h33, 4'b0010, 1'b1);
        tick();
        drive(1, 8'h44, 4'b0101, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t4_status_first", 32'(status),    32'h2);
        chk("t4_flags_second", 32'(out_flags), 32'h5);
        tick();
        chk("t4_status_kept",  32'(status),    32'h2);

        // 5: reset with output and skid both full
        out_ready = 1'b0;
        drive(0, 8'h55, 4'b1111, 1'b1);
        tick();
        drive(0, 8'h66, 4'b1111, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t5_full", 32'(in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_in_ready",  32'(in_ready),  1);
        chk("t5_status",    32'(status),    0);
        out_ready = 1'b1;
        tick();
        chk("t5_no_ghost",  32'(out_valid), 0);
        chk("t5_status2",   32'(status),    0);

        // 6: clear wins over a same-cycle update
        drive(3, 8'h77, 4'b1111, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t6_pre_valid", 32'(out_valid), 1);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("t6_clr_prio", 32'(status),    0);
        chk("t6_drained",  32'(out_valid), 0);

        // 6b: 16-word burst with out_ready toggling every cycle
        sent = 0; rcvd = 0; cycles = 0;
        out_ready = 1'b0;
        while (rcvd < 16 && cycles < 200) begin
            if (sent < 16) drive(1, 8'(8'h40 + sent), 4'(sent), 1'b1);
            else in_valid = 1'b0;
            out_ready = ~out_ready;
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                chk("t6_burst_word", 32'(out_data), 32'(8'h40 + rcvd));
                rcvd++;
            end
            if (fire_in) sent++;
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        chk("t6_burst_count", 32'(rcvd), 16);
        chk("t6_burst_last_status", 32'(status), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
